// File: rtl/instr_issue_buffer_if.sv
// Handshake bundle between an opcode source and the instruction issue buffer.
// Signal names keep the buffer-side direction suffixes so both ends read the same.
interface instr_issue_buffer_if #(
  parameter int DEPTH = 8
);
  localparam int OW = $clog2(DEPTH + 1);

  logic          in_valid_i;
  logic [3:0]    in_opcode_i;
  logic          in_ready_o;
  logic          stall_i;
  logic          flush_i;
  logic [3:0]    opcode_o;
  logic          valid_o;
  logic          mode_o;
  logic [OW-1:0] occupancy_o;

  modport master (
    output in_valid_i, in_opcode_i, stall_i, flush_i,
    input  in_ready_o, opcode_o, valid_o, mode_o, occupancy_o
  );

  modport slave (
    input  in_valid_i, in_opcode_i, stall_i, flush_i,
    output in_ready_o, opcode_o, valid_o, mode_o, occupancy_o
  );
endinterface

// File: rtl/instr_issue_buffer.sv
// Opcode FIFO that issues one opcode per cycle, plus an occupancy-driven
// LowPower/HighPerf mode governor with a dwell filter against chatter.
//
// state     | meaning
// LOW_POWER | mode_o=0, waiting for occupancy >= HI_THRESH for HOLD_CYCLES edges
// HIGH_PERF | mode_o=1, waiting for occupancy <= LO_THRESH for HOLD_CYCLES edges
module instr_issue_buffer #(
  parameter int DEPTH       = 8,
  parameter int HI_THRESH   = 6,
  parameter int LO_THRESH   = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  instr_issue_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {
    LOW_POWER = 1'b0,
    HIGH_PERF = 1'b1
  } mode_t;

  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [OW-1:0] occ;
  logic [3:0]    opcode_q;
  logic          valid_q;
  logic          full;
  logic          push;
  logic          pop;

  mode_t         state;
  mode_t         state_nxt;
  logic [DW-1:0] dwell;
  logic [DW-1:0] dwell_nxt;
  logic          qual;

  assign full = (occ == OW'(DEPTH));
  // Flush outranks both sides, so neither pointer moves on a flush edge.
  assign push = bus.in_valid_i && !full && !bus.flush_i;
  assign pop  = !bus.stall_i && (occ != '0) && !bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_opcode_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      opcode_q <= '0;
      valid_q  <= 1'b0;
    end else if (bus.flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        opcode_q <= mem[rd_ptr];
      end
      valid_q <= pop;
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= LOW_POWER;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      dwell <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dwell_nxt = dwell;
    qual      = 1'b0;
    case (state)
      LOW_POWER: qual = (occ >= OW'(HI_THRESH));
      HIGH_PERF: qual = (occ <= OW'(LO_THRESH));
      default:   qual = 1'b0;
    endcase
    if (bus.flush_i || !qual) begin
      dwell_nxt = '0;
    end else if (dwell == DW'(HOLD_CYCLES - 1)) begin
      state_nxt = (state == LOW_POWER) ? HIGH_PERF : LOW_POWER;
      dwell_nxt = '0;
    end else begin
      dwell_nxt = dwell + DW'(1);
    end
  end

  assign bus.in_ready_o  = !full;
  assign bus.opcode_o    = opcode_q;
  assign bus.valid_o     = valid_q;
  assign bus.mode_o      = (state == HIGH_PERF);
  assign bus.occupancy_o = occ;
endmodule
